riscv_lsu: RTL and testbench

Load/store unit between the `riscv_core` data-memory port and the data memory. It turns byte, halfword and word requests from the core into word-aligned memory transactions with byte enables. It replicates write data across byte lanes and extracts and extends read data. It also generates the core's `stall_i`, holding the core until the memory answers, and flags misaligned, illegal-size and timed-out accesses.

---
 rtl/riscv_lsu_if.sv | 33 +++
 rtl/riscv_lsu.sv | 152 +++++++++++++++
 tb/tb_riscv_lsu.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_lsu_if.sv
// Core-side and memory-side signals of the load/store unit, bundled as one interface.
// The LSU connects through the slave modport; the core/memory environment uses master.
interface riscv_lsu_if;
    logic        core_req_i;
    logic        core_we_i;
    logic [2:0]  core_size_i;
    logic [31:0] core_addr_i;
    logic [31:0] core_wd_i;
    logic [31:0] core_rd_o;
    logic        core_stall_o;
    logic        lsu_err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wd_o;
    logic [31:0] mem_rd_i;
    logic        mem_ready_i;

    modport slave (
        input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        input  mem_rd_i, mem_ready_i,
        output core_rd_o, core_stall_o, lsu_err_o,
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );

    modport master (
        output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
        output mem_rd_i, mem_ready_i,
        input  core_rd_o, core_stall_o, lsu_err_o,
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
    );
endinterface

// File: rtl/riscv_lsu.sv
// Load/store unit: turns core byte/half/word accesses into word-aligned memory
// transactions, stalls the core until memory answers, and flags bad or timed-out accesses.
module riscv_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    riscv_lsu_if.slave  bus
);

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    state_t      state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  size_q, size_d;
    logic [15:0] cnt_q, cnt_d;
    logic        err_q, err_d;

    logic        legal;
    logic        mem_req;
    logic        stall;
    logic [31:0] rd_data;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [31:0] shifted;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;

    // Alignment and size legality of the access currently presented by the core.
    always_comb begin
        legal = 1'b0;
        case (bus.core_size_i)
            3'd0, 3'd4: legal = 1'b1;
            3'd1, 3'd5: legal = ~bus.core_addr_i[0];
            3'd2:       legal = (bus.core_addr_i[1:0] == 2'b00);
            default:    legal = 1'b0;
        endcase
    end

    always_comb begin
        be_c = 4'b1111;
        wd_c = bus.core_wd_i;
        case (bus.core_size_i[1:0])
            2'd0: begin
                be_c = 4'b0001 << bus.core_addr_i[1:0];
                wd_c = {4{bus.core_wd_i[7:0]}};
            end
            2'd1: begin
                be_c = bus.core_addr_i[1] ? 4'b1100 : 4'b0011;
                wd_c = {2{bus.core_wd_i[15:0]}};
            end
            default: begin
                be_c = 4'b1111;
                wd_c = bus.core_wd_i;
            end
        endcase
    end

    // Read data is aligned with the offset and size captured when the access started.
    always_comb begin
        shifted   = bus.mem_rd_i >> {off_q, 3'b000};
        byte_v    = shifted[7:0];
        half_v    = off_q[1] ? bus.mem_rd_i[31:16] : bus.mem_rd_i[15:0];
        load_data = bus.mem_rd_i;
        case (size_q)
            3'd0:    load_data = {{24{byte_v[7]}}, byte_v};
            3'd4:    load_data = {24'h000000, byte_v};
            3'd1:    load_data = {{16{half_v[15]}}, half_v};
            3'd5:    load_data = {16'h0000, half_v};
            default: load_data = bus.mem_rd_i;
        endcase
    end

    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        mem_req = 1'b0;
        stall   = 1'b0;
        rd_data = 32'h0;
        case (state_q)
            ST_IDLE: begin
                if (bus.core_req_i) begin
                    if (legal) begin
                        mem_req = 1'b1;
                        stall   = 1'b1;
                        off_d   = bus.core_addr_i[1:0];
                        size_d  = bus.core_size_i;
                        cnt_d   = 16'h0;
                        state_d = ST_WAIT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_WAIT: begin
                if (!bus.core_req_i) begin
                    state_d = ST_IDLE;
                end else begin
                    mem_req = 1'b1;
                    // Ready has priority over the timeout check in the same cycle.
                    if (bus.mem_ready_i) begin
                        rd_data = bus.core_we_i ? 32'h0 : load_data;
                        state_d = ST_IDLE;
                    end else if (cnt_q == 16'(TIMEOUT)) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // While reset is held the request is abandoned immediately, even if the core keeps asking.
        if (!rst_i) begin
            mem_req = 1'b0;
            stall   = 1'b0;
            rd_data = 32'h0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            off_q   <= 2'b00;
            size_q  <= 3'd0;
            cnt_q   <= 16'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            off_q   <= off_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.mem_req_o    = mem_req;
    assign bus.mem_we_o     = mem_req & bus.core_we_i;
    assign bus.mem_be_o     = mem_req ? be_c : 4'b0000;
    assign bus.mem_addr_o   = mem_req ? {bus.core_addr_i[31:2], 2'b00} : 32'h0;
    assign bus.mem_wd_o     = mem_req ? wd_c : 32'h0;
    assign bus.core_stall_o = stall;
    assign bus.core_rd_o    = rd_data;
    assign bus.lsu_err_o    = err_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: two instances (default and short timeout) share stimulus
// and are checked every cycle against a byte-lane level model, plus literal spot checks.
module tb_riscv_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we, ready;
    logic [2:0]  size;
    logic [31:0] addr, wd, mrd;

    int tests = 0;
    int fails = 0;

    riscv_lsu_if bus0 ();
    riscv_lsu_if bus1 ();

    assign bus0.core_req_i  = req;
    assign bus0.core_we_i   = we;
    assign bus0.core_size_i = size;
    assign bus0.core_addr_i = addr;
    assign bus0.core_wd_i   = wd;
    assign bus0.mem_rd_i    = mrd;
    assign bus0.mem_ready_i = ready;

    assign bus1.core_req_i  = req;
    assign bus1.core_we_i   = we;
    assign bus1.core_size_i = size;
    assign bus1.core_addr_i = addr;
    assign bus1.core_wd_i   = wd;
    assign bus1.mem_rd_i    = mrd;
    assign bus1.mem_ready_i = ready;

    riscv_lsu #(.TIMEOUT(255)) dut    (.clk_i(clk), .rst_i(rst_n), .bus(bus0));
    riscv_lsu #(.TIMEOUT(4))   dut_to (.clk_i(clk), .rst_i(rst_n), .bus(bus1));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rd;
        logic        stall;
        logic        err;
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wd;
    } outs_t;

    outs_t obs [2];
    assign obs[0] = {bus0.core_rd_o, bus0.core_stall_o, bus0.lsu_err_o, bus0.mem_req_o,
                     bus0.mem_we_o, bus0.mem_be_o, bus0.mem_addr_o, bus0.mem_wd_o};
    assign obs[1] = {bus1.core_rd_o, bus1.core_stall_o, bus1.lsu_err_o, bus1.mem_req_o,
                     bus1.mem_we_o, bus1.mem_be_o, bus1.mem_addr_o, bus1.mem_wd_o};

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Access model in terms of bytes: width, lane window, replication, extension.
    function automatic int nbytes(input logic [2:0] s);
        case (s[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    function automatic bit is_legal(input logic [2:0] s, input logic [31:0] a);
        if (s == 3'd3 || s >= 3'd6) return 1'b0;
        return (int'(a[1:0]) % nbytes(s)) == 0;
    endfunction

    function automatic logic [3:0] exp_be(input logic [2:0] s, input logic [31:0] a);
        int n = nbytes(s);
        int st = (int'(a[1:0]) / n) * n;
        logic [3:0] r = 4'b0000;
        for (int i = 0; i < 4; i++)
            if (i >= st && i < st + n) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] exp_wd(input logic [2:0] s, input logic [31:0] d);
        int n = nbytes(s);
        logic [31:0] r = 32'h0;
        for (int i = 0; i < 4; i++)
            r[i*8 +: 8] = d[(i % n)*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_load(input logic [2:0] s, input logic [1:0] off, input logic [31:0] w);
        int n = nbytes(s);
        int st = (int'(off) / n) * n;
        logic [31:0] v = w >> (8 * st);
        if (n == 1) begin
            v = v & 32'h000000FF;
            if (s == 3'd0 && v[7]) v = v | 32'hFFFFFF00;
        end else if (n == 2) begin
            v = v & 32'h0000FFFF;
            if (s == 3'd1 && v[15]) v = v | 32'hFFFF0000;
        end
        return v;
    endfunction

    int       tmo    [2] = '{255, 4};
    bit       m_busy [2];
    bit [1:0] m_off  [2];
    bit [2:0] m_sz   [2];
    int       m_cnt  [2];
    bit       m_err  [2];
    bit       n_busy [2];
    bit [1:0] n_off  [2];
    bit [2:0] n_sz   [2];
    int       n_cnt  [2];
    bit       n_err  [2];

    // Every falling edge: predict both instances' outputs and their next model state.
    always @(negedge clk) begin : compare
        outs_t e;
        bit    lanes;
        string tag;
        for (int k = 0; k < 2; k++) begin
            e = '0;
            lanes = 1'b0;
            tag = (k == 0) ? "dut" : "dut_to";
            n_busy[k] = m_busy[k];
            n_off[k]  = m_off[k];
            n_sz[k]   = m_sz[k];
            n_cnt[k]  = m_cnt[k];
            n_err[k]  = 1'b0;
            if (!rst_n) begin
                n_busy[k] = 1'b0;
                n_cnt[k]  = 0;
            end else begin
                e.err = m_err[k];
                if (!m_busy[k]) begin
                    if (req && is_legal(size, addr)) begin
                        e.req = 1'b1; e.stall = 1'b1; lanes = 1'b1;
                        n_busy[k] = 1'b1; n_off[k] = addr[1:0]; n_sz[k] = size; n_cnt[k] = 0;
                    end else if (req) begin
                        n_err[k] = 1'b1;
                    end
                end else if (!req) begin
                    n_busy[k] = 1'b0;
                end else begin
                    e.req = 1'b1; lanes = 1'b1;
                    if (ready) begin
                        e.rd = we ? 32'h0 : exp_load(m_sz[k], m_off[k], mrd);
                        n_busy[k] = 1'b0;
                    end else if (m_cnt[k] == tmo[k]) begin
                        n_err[k] = 1'b1;
                        n_busy[k] = 1'b0;
                    end else begin
                        e.stall = 1'b1;
                        n_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
            if (lanes) begin
                e.we = we; e.be = exp_be(size, addr);
                e.addr = {addr[31:2], 2'b00}; e.wd = exp_wd(size, wd);
            end
            checkOutput({tag, " core_rd"}, obs[k].rd, e.rd);
            checkOutput({tag, " stall"}, 32'(obs[k].stall), 32'(e.stall));
            checkOutput({tag, " lsu_err"}, 32'(obs[k].err), 32'(e.err));
            checkOutput({tag, " mem_req"}, 32'(obs[k].req), 32'(e.req));
            checkOutput({tag, " mem_we"}, 32'(obs[k].we), 32'(e.we));
            if (lanes || (rst_n && !req && !ready)) begin
                checkOutput({tag, " mem_be"}, 32'(obs[k].be), 32'(e.be));
                checkOutput({tag, " mem_addr"}, obs[k].addr, e.addr);
                checkOutput({tag, " mem_wd"}, obs[k].wd, e.wd);
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_busy[k] = 1'b0; m_cnt[k] = 0; m_err[k] = 1'b0;
            end else begin
                m_busy[k] = n_busy[k]; m_off[k] = n_off[k]; m_sz[k] = n_sz[k];
                m_cnt[k] = n_cnt[k]; m_err[k] = n_err[k];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit r, input bit w, input logic [2:0] s,
                                 input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; size = s; addr = a; wd = d;
    endtask

    int stalls;

    initial begin
        rst_n = 1'b0;
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0);
        ready = 1'b0;
        mrd = 32'h0;
        @(negedge clk);
        checkOutput("reset stall", 32'(bus0.core_stall_o), 32'h0);
        checkOutput("reset mem_req", 32'(bus0.mem_req_o), 32'h0);
        checkOutput("reset lsu_err", 32'(bus0.lsu_err_o), 32'h0);
        checkOutput("reset core_rd", bus0.core_rd_o, 32'h0);
        tick();
        rst_n = 1'b1;

        // Word load, ready in first WAIT cycle
        tick();
        applyStimulus(1, 0, 3'd2, 32'h100, 32'h0);
        @(negedge clk);
        checkOutput("lw be", 32'(bus0.mem_be_o), 32'hF);
        checkOutput("lw addr", bus0.mem_addr_o, 32'h100);
        checkOutput("lw stall c0", 32'(bus0.core_stall_o), 32'h1);
        tick();
        ready = 1'b1; mrd = 32'hDEADBEEF;
        @(negedge clk);
        checkOutput("lw stall c1", 32'(bus0.core_stall_o), 32'h0);
        checkOutput("lw rd", bus0.core_rd_o, 32'hDEADBEEF);
        tick();
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0); ready = 1'b0;

        // LB then back-to-back LBU at 0x103; ready held high in IDLE must be ignored
        tick();
        applyStimulus(1, 0, 3'd0, 32'h103, 32'h0); mrd = 32'h80112233;
        @(negedge clk);
        checkOutput("lb be", 32'(bus0.mem_be_o), 32'h8);
        tick();
        ready = 1'b1;
        @(negedge clk);
        checkOutput("lb rd", bus0.core_rd_o, 32'hFFFFFF80);
        tick();
        applyStimulus(1, 0, 3'd4, 32'h103, 32'h0);
        @(negedge clk);
        checkOutput("lbu idle stall", 32'(bus0.core_stall_o), 32'h1);
        checkOutput("lbu idle rd", bus0.core_rd_o, 32'h0);
        tick();
        @(negedge clk);
        checkOutput("lbu rd", bus0.core_rd_o, 32'h00000080);
        tick();
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0); ready = 1'b0;

        // SH at 0x202
        tick();
        applyStimulus(1, 1, 3'd1, 32'h202, 32'h1234ABCD);
        @(negedge clk);
        checkOutput("sh we", 32'(bus0.mem_we_o), 32'h1);
        checkOutput("sh be", 32'(bus0.mem_be_o), 32'hC);
        checkOutput("sh wd", bus0.mem_wd_o, 32'hABCDABCD);
        checkOutput("sh addr", bus0.mem_addr_o, 32'h200);
        tick();
        ready = 1'b1;
        @(negedge clk);
        checkOutput("sh stall", 32'(bus0.core_stall_o), 32'h0);
        checkOutput("sh rd", bus0.core_rd_o, 32'h0);
        tick();
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0); ready = 1'b0;

        // SB at 0x001 and LH at 0x000
        tick();
        applyStimulus(1, 1, 3'd0, 32'h1, 32'h000000A5);
        @(negedge clk);
        checkOutput("sb be", 32'(bus0.mem_be_o), 32'h2);
        checkOutput("sb wd", bus0.mem_wd_o, 32'hA5A5A5A5);
        tick();
        ready = 1'b1;
        tick();
        applyStimulus(1, 0, 3'd1, 32'h0, 32'h0); ready = 1'b0; mrd = 32'h12348001;
        @(negedge clk);
        checkOutput("lh be", 32'(bus0.mem_be_o), 32'h3);
        tick();
        ready = 1'b1;
        @(negedge clk);
        checkOutput("lh rd", bus0.core_rd_o, 32'hFFFF8001);
        tick();
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0); ready = 1'b0;

        // Misaligned LW, then illegal size 3
        for (int t = 0; t < 2; t++) begin
            tick();
            if (t == 0) applyStimulus(1, 0, 3'd2, 32'h101, 32'h0);
            else        applyStimulus(1, 0, 3'd3, 32'h100, 32'h0);
            @(negedge clk);
            checkOutput("bad mem_req", 32'(bus0.mem_req_o), 32'h0);
            checkOutput("bad stall", 32'(bus0.core_stall_o), 32'h0);
            checkOutput("bad err early", 32'(bus0.lsu_err_o), 32'h0);
            tick();
            applyStimulus(0, 0, 3'd0, 32'h0, 32'h0);
            @(negedge clk);
            checkOutput("bad err pulse", 32'(bus0.lsu_err_o), 32'h1);
            tick();
            @(negedge clk);
            checkOutput("bad err width", 32'(bus0.lsu_err_o), 32'h0);
        end

        // LHU at 0x006 with five not-ready WAIT cycles
        tick();
        applyStimulus(1, 0, 3'd5, 32'h6, 32'h0); mrd = 32'hF00D0000;
        stalls = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus0.core_stall_o) stalls++;
            tick();
        end
        ready = 1'b1;
        @(negedge clk);
        checkOutput("lhu stall cycles", 32'(stalls), 32'd6);
        checkOutput("lhu final stall", 32'(bus0.core_stall_o), 32'h0);
        checkOutput("lhu rd", bus0.core_rd_o, 32'h0000F00D);
        tick();
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0); ready = 1'b0;

        // Timeout on the TIMEOUT=4 instance
        tick();
        tick();
        applyStimulus(1, 0, 3'd2, 32'h300, 32'h0);
        stalls = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus1.core_stall_o) stalls++;
            tick();
        end
        @(negedge clk);
        checkOutput("to stall cycles", 32'(stalls), 32'd5);
        checkOutput("to release stall", 32'(bus1.core_stall_o), 32'h0);
        checkOutput("to rd", bus1.core_rd_o, 32'h0);
        tick();
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        checkOutput("to err pulse", 32'(bus1.lsu_err_o), 32'h1);
        checkOutput("to no err on long dut", 32'(bus0.lsu_err_o), 32'h0);
        tick();
        @(negedge clk);
        checkOutput("to err width", 32'(bus1.lsu_err_o), 32'h0);

        // Ready arrives in the very cycle the counter hits TIMEOUT: ready wins
        tick();
        applyStimulus(1, 0, 3'd2, 32'h600, 32'h0); mrd = 32'hCAFEF00D;
        for (int i = 0; i < 5; i++) tick();
        ready = 1'b1;
        @(negedge clk);
        checkOutput("race rd", bus1.core_rd_o, 32'hCAFEF00D);
        checkOutput("race stall", 32'(bus1.core_stall_o), 32'h0);
        tick();
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0); ready = 1'b0;
        @(negedge clk);
        checkOutput("race no err", 32'(bus1.lsu_err_o), 32'h0);

        // Reset asserted mid-WAIT with the core still requesting
        tick();
        applyStimulus(1, 0, 3'd2, 32'h700, 32'h0); mrd = 32'h01020304;
        tick();
        @(negedge clk);
        checkOutput("rst pre mem_req", 32'(bus0.mem_req_o), 32'h1);
        checkOutput("rst pre stall", 32'(bus0.core_stall_o), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst mem_req", 32'(bus0.mem_req_o), 32'h0);
        checkOutput("rst stall", 32'(bus0.core_stall_o), 32'h0);
        checkOutput("rst mem_req to", 32'(bus1.mem_req_o), 32'h0);
        checkOutput("rst stall to", 32'(bus1.core_stall_o), 32'h0);
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst restart stall", 32'(bus0.core_stall_o), 32'h1);
        checkOutput("rst no err", 32'(bus0.lsu_err_o), 32'h0);
        tick();
        ready = 1'b1;
        @(negedge clk);
        checkOutput("rst restart rd", bus0.core_rd_o, 32'h01020304);
        tick();
        applyStimulus(0, 0, 3'd0, 32'h0, 32'h0); ready = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
